// File: rtl/sm4_round_core_if.sv
// Block/result handshake and round-key lookup bundle for the SM4 round core.
// The core takes the slave side; the producer/consumer/key store take master.
interface sm4_round_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic         dec;
    logic [4:0]   rk_addr;
    logic [31:0]  rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;

    modport master (
        output in_valid, din, dec, rk_data, out_ready,
        input  in_ready, rk_addr, out_valid, dout
    );

    modport slave (
        input  in_valid, din, dec, rk_data, out_ready,
        output in_ready, rk_addr, out_valid, dout
    );
endinterface

// File: rtl/sm4_round_core.sv
// Iterative SM4 block cipher core: one round per cycle, out_valid 32 edges after accept.
// Accepts only in IDLE; in DONE the result holds until out_ready, then one IDLE cycle follows.
module sm4_round_core (
    input  logic             clk,
    input  logic             rst,
    sm4_round_core_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] SBOX [0:255] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // Encryption T-transform: bytewise S-box followed by the linear diffusion L.
    function automatic logic [31:0] trans_enc(input logic [31:0] a);
        logic [31:0] b;
        b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    logic [1:0]   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  x0_q, x0_d, x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
    logic         dec_q, dec_d;
    logic [127:0] dout_q, dout_d;
    logic [31:0]  rnd_t;
    logic [31:0]  x_new;

    assign rnd_t = x1_q ^ x2_q ^ x3_q ^ bus.rk_data;
    assign x_new = x0_q ^ trans_enc(rnd_t);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        dec_d   = dec_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x0_d    = bus.din[127:96];
                    x1_d    = bus.din[95:64];
                    x2_d    = bus.din[63:32];
                    x3_d    = bus.din[31:0];
                    dec_d   = bus.dec;
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                x0_d = x1_q;
                x1_d = x2_q;
                x2_d = x3_q;
                x3_d = x_new;
                if (cnt_q == 5'd31) begin
                    // Final round: capture the word-reversed result straight from the new words.
                    dout_d  = {x_new, x3_q, x2_q, x1_q};
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            x0_q    <= 32'd0;
            x1_q    <= 32'd0;
            x2_q    <= 32'd0;
            x3_q    <= 32'd0;
            dec_q   <= 1'b0;
            dout_q  <= 128'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            dec_q   <= dec_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.dout      = dout_q;
    assign bus.rk_addr   = (state_q != S_RUN) ? 5'd0 :
                           dec_q ? (5'd31 - cnt_q) : cnt_q;
endmodule

// File: tb/tb_sm4_round_core.sv
// Bench for sm4_round_core: known-answer vectors, backpressure, abort and streaming.
module tb_sm4_round_core;
    logic clk;
    logic rst;
    sm4_round_core_if bus ();

    sm4_round_core dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] SB [0:255] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

    logic [31:0] rk_tab [32];
    assign bus.rk_data = rk_tab[bus.rk_addr];

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [127:0] blk;
        logic         d;
        logic [127:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tf(input logic [31:0] a, input bit key_sched);
        logic [31:0] b;
        b = {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
        if (key_sched) return b ^ rol(b, 13) ^ rol(b, 23);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    task automatic expand_key(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] fk [4];
        logic [31:0] ck;
        fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
        for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            ck = 32'd0;
            for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'(((4*i + j) * 7) % 256)};
            k[i+4] = k[i] ^ tf(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck, 1'b1);
            rk_tab[i] = k[i+4];
        end
    endtask

    function automatic logic [127:0] ref_sm4(input logic [127:0] blk, input logic d);
        logic [31:0] x [36];
        for (int i = 0; i < 4; i++) x[i] = blk[127 - 32*i -: 32];
        for (int i = 0; i < 32; i++)
            x[i+4] = x[i] ^ tf(x[i+1] ^ x[i+2] ^ x[i+3] ^ (d ? rk_tab[31-i] : rk_tab[i]), 1'b0);
        return {x[35], x[34], x[33], x[32]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!bus.in_ready && w < 100) begin @(posedge clk); #1; w++; end
    endtask

    // Full transaction: accept, track latency and key order, optional hold in DONE, handoff.
    task automatic run_block(input logic [127:0] blk, input logic d, input int hold,
                             input bit scramble, input string tag);
        logic [127:0] exp, held;
        int lat;
        bit seq_ok, stable;
        exp = ref_sm4(blk, d);
        wait_ready();
        bus.din = blk; bus.dec = d; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0; seq_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (lat < 32) seq_ok &= (bus.rk_addr == (d ? 5'(31 - lat) : 5'(lat)));
            if (scramble) begin
                bus.din = rnd128(); bus.dec = 1'($urandom); bus.in_valid = 1'($urandom);
            end
            @(posedge clk); #1; lat++;
        end
        bus.in_valid = 1'b0;
        chk({tag, " latency"}, 128'(lat), 128'd32);
        chk({tag, " rk_addr order"}, 128'(seq_ok), 128'd1);
        chk({tag, " dout"}, bus.dout, exp);
        held = bus.dout; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = ~bus.in_valid; bus.din = rnd128(); bus.dec = ~bus.dec;
            @(posedge clk); #1;
            stable &= bus.out_valid && !bus.in_ready && (bus.dout == held);
        end
        if (hold > 0) chk({tag, " hold stable"}, 128'(stable), 128'd1);
        bus.out_ready = 1'b1;
        bus.in_valid = (hold > 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        chk({tag, " out_valid after handoff"}, 128'(bus.out_valid), 128'd0);
        chk({tag, " in_ready after handoff"}, 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        vec_t vecs [4];
        logic [127:0] q [$];
        logic [127:0] exp;
        int w, pulses, n_acc, n_out, last, cyc;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.din = '0; bus.dec = 1'b0;
        expand_key(KEY);
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 128'(bus.in_ready), 128'd1);
        chk("reset out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset dout", bus.dout, 128'd0);
        chk("reset rk_addr", 128'(bus.rk_addr), 128'd0);
        chk("rk[0]", 128'(rk_tab[0]), 128'(32'hf12186f9));
        chk("rk[31]", 128'(rk_tab[31]), 128'(32'h9124a012));
        rst = 1'b0;
        @(posedge clk); #1;

        vecs[0] = '{KEY, 1'b0, CT};
        vecs[1] = '{CT, 1'b1, KEY};
        vecs[2].blk = rnd128(); vecs[2].d = 1'b0; vecs[2].exp = ref_sm4(vecs[2].blk, 1'b0);
        vecs[3].blk = vecs[2].exp; vecs[3].d = 1'b1; vecs[3].exp = vecs[2].blk;
        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_block(vecs[i].blk, vecs[i].d, 0, 1'b0, tag);
            chk({tag, " table expect"}, ref_sm4(vecs[i].blk, vecs[i].d), vecs[i].exp);
        end

        run_block(rnd128(), 1'b0, 10, 1'b0, "backpressure");
        run_block(rnd128(), 1'b1, 0, 1'b1, "ignore_in_run");

        // Abort at round 15.
        wait_ready();
        bus.din = KEY; bus.dec = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        w = 0;
        while (bus.rk_addr != 5'd15 && w < 100) begin @(posedge clk); #1; w++; end
        chk("abort reached round 15", 128'(bus.rk_addr), 128'd15);
        #2 rst = 1'b1;
        #1;
        chk("abort in_ready", 128'(bus.in_ready), 128'd1);
        chk("abort out_valid", 128'(bus.out_valid), 128'd0);
        chk("abort dout", bus.dout, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid || !bus.in_ready) pulses++;
        end
        chk("abort no output", 128'(pulses), 128'd0);
        run_block(KEY, 1'b0, 0, 1'b0, "after_abort");

        // Streaming with in_valid and out_ready held high.
        bus.out_ready = 1'b1;
        n_acc = 0; n_out = 0; last = 0; cyc = 0;
        while (n_out < 8 && cyc < 600) begin
            if (bus.out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : 128'hx;
                chk($sformatf("b2b dout %0d", n_out), bus.dout, exp);
                if (n_out > 0) chk($sformatf("b2b spacing %0d", n_out), 128'(cyc - last), 128'd34);
                last = cyc;
                n_out++;
            end
            bus.din = rnd128(); bus.dec = 1'($urandom);
            bus.in_valid = (n_acc < 8);
            if (bus.in_ready && n_acc < 8) begin
                q.push_back(ref_sm4(bus.din, bus.dec));
                n_acc++;
            end
            @(posedge clk); #1; cyc++;
        end
        chk("b2b block count", 128'(n_out), 128'd8);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sm4_round_core.md
SM4_ROUND_CORE -- requirements
Module: sm4_round_core

Interface
REQ-001 Parameters: none; round count fixed at 32, word width fixed at 32.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  input block and mode present.
REQ-006 in_ready  output  1  core can accept a block.
REQ-007 din  input  128  block; din[127:96]=X0, din[95:64]=X1, din[63:32]=X2, din[31:0]=X3.
REQ-008 dec  input  1  sampled with din; 0 encrypt, 1 decrypt.
REQ-009 rk_addr  output  5  round-key index requested this cycle.
REQ-010 rk_data  input  32  round key rk[rk_addr]; combinational, same-cycle.
REQ-011 out_valid  output  1  dout holds a finished block.
REQ-012 out_ready  input  1  consumer accepts dout.
REQ-013 dout  output  128  result {X35,X34,X33,X32}, X35 in [127:96].

Function
REQ-014 The core SHALL use FSM states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid=1, latch din into registers X0..X3, latch dec, set cnt=0 and go to RUN; otherwise stay.
REQ-017 RUN: each cycle, compute t = X1^X2^X3^rk_data.
REQ-018 RUN: each cycle, pass t through the existing trans_enc T-transform to get T(t).
REQ-019 RUN: each cycle, set Xnew = X0 ^ T(t).
REQ-020 RUN: each cycle, shift {X0,X1,X2,X3} <= {X1,X2,X3,Xnew}; increment cnt.
REQ-021 rk_addr SHALL equal cnt when dec=0 and 31-cnt when dec=1 in RUN; 0 elsewhere.
REQ-022 cnt is 5 bits; after the round with cnt=31, the FSM SHALL go to DONE without wrapping.
REQ-023 At the DONE transition, dout SHALL be loaded with the word-reversed registers {X3,X2,X1,X0}.
REQ-024 Latency: out_valid SHALL rise exactly 32 clock edges after the accepting edge; the core performs exactly 32 round updates.
REQ-025 DONE: dout and out_valid SHALL hold stable while out_ready=0.
REQ-026 DONE: on out_ready=1, go to IDLE and drop out_valid next cycle.
REQ-027 No new block SHALL be accepted in the same cycle as output handoff; earliest acceptance is the following cycle.
REQ-028 in_valid, din and dec SHALL be ignored in RUN and DONE; the in-flight block is unaffected.
REQ-029 Throughput: one block per 34 cycles minimum with out_ready tied high.

Reset
REQ-030 On rst=1, the core SHALL immediately reach state IDLE, regardless of clock.
REQ-031 On rst=1, cnt, X0..X3, dec latch and dout SHALL clear to 0.
REQ-032 On rst=1, out_valid=0 and in_ready=1 (after any in-progress clock edge).
REQ-033 Reset mid-RUN or mid-DONE SHALL abort the block with no out_valid pulse; operation resumes from IDLE on the first edge after rst falls.

Verification
REQ-034 Encrypt: key table from key 0123456789abcdeffedcba9876543210 (rk[0]=f12186f9, rk[31]=9124a012), din=0123456789abcdeffedcba9876543210, dec=0 -> dout=681edf34d206965e86b3e94f536e4246, 32 edges after accept.
REQ-035 Decrypt: same key table, din=681edf34d206965e86b3e94f536e4246, dec=1 -> dout=0123456789abcdeffedcba9876543210; rk_addr sequence 31..0.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling in_valid and din -> dout unchanged, in_ready=0; accept on out_ready=1, in_ready=1 the next cycle.
REQ-037 Reset abort: assert rst at round 15 -> out_valid stays 0, dout=0, in_ready=1; a new block then produces the correct result.
REQ-038 Back-to-back: 8 random blocks, in_valid and out_ready held high -> each result matches the model, with 34-cycle spacing between out_valid pulses.
REQ-039 Ignore-in-RUN: change din and dec during RUN -> the result matches the originally accepted block.
